// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes
// (also used by the ALU control decoder) and FSM state encodings.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // The two signed operations share a clear op[0], so signedness is one bit.
    function automatic logic md_op_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic md_op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_sign_fix.sv
// Conditional two's-complement negate. It takes the absolute value of an
// operand (neg_i = operand sign) and restores the sign of a result.
module muldiv_unit_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One shift-add or restoring-divide step is done per cycle, for WIDTH cycles.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               sign1, sign2, accept, last;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [2*WIDTH-1:0] mul_next, prod_fixed;
    logic               div_ge;
    logic [WIDTH-1:0]   quot_next, rem_next, quot_fixed, rem_fixed;

    assign sign1 = md_op_signed(op_i) & src1_i[WIDTH-1];
    assign sign2 = md_op_signed(op_i) & src2_i[WIDTH-1];

    muldiv_unit_sign_fix #(.W(WIDTH)) u_abs1 (.val_i(src1_i), .neg_i(sign1), .val_o(abs1));
    muldiv_unit_sign_fix #(.W(WIDTH)) u_abs2 (.val_i(src2_i), .neg_i(sign2), .val_o(abs2));

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, opnd_q} & {(WIDTH+1){acc_q[0]}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc low half shifts dividend bits out and quotient bits in.
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign rem_next  = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
    assign quot_next = {acc_q[WIDTH-2:0], div_ge};

    muldiv_unit_sign_fix #(.W(2*WIDTH)) u_prod_fix (.val_i(mul_next),  .neg_i(neg_res_q), .val_o(prod_fixed));
    muldiv_unit_sign_fix #(.W(WIDTH))   u_quot_fix (.val_i(quot_next), .neg_i(neg_res_q), .val_o(quot_fixed));
    muldiv_unit_sign_fix #(.W(WIDTH))   u_rem_fix  (.val_i(rem_next),  .neg_i(neg_rem_q), .val_o(rem_fixed));

    assign accept = start_i && (state_q != MD_RUN);
    assign last   = (state_q == MD_RUN) && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            MD_RUN:  state_d = last ? MD_DONE : MD_RUN;
            default: state_d = start_i ? MD_RUN : MD_IDLE;
        endcase

        if (accept) begin
            cnt_d      = '0;
            is_div_d   = md_op_is_div(op_i);
            neg_res_d  = sign1 ^ sign2;
            neg_rem_d  = sign1;
            div_zero_d = md_op_is_div(op_i) && (src2_i == '0);
            opnd_d     = md_op_is_div(op_i) ? abs2 : abs1;
            acc_d      = {{WIDTH{1'b0}}, (md_op_is_div(op_i) ? abs1 : abs2)};
            rem_d      = '0;
        end else if (state_q == MD_RUN) begin
            cnt_d = cnt_q + CW'(1);
            if (is_div_q) begin
                acc_d = {acc_q[2*WIDTH-1:WIDTH], quot_next};
                rem_d = rem_next;
            end else begin
                acc_d = mul_next;
            end
            if (last) begin
                done_d = 1'b1;
                if (is_div_q) begin
                    // Divide by zero: the remainder path already yields src1, only LO is forced.
                    lo_d = div_zero_q ? '1 : quot_fixed;
                    hi_d = rem_fixed;
                end else begin
                    {hi_d, lo_d} = prod_fixed;
                end
            end
        end else begin
            if (hi_we_i) hi_d = wdata_i;
            if (lo_we_i) lo_d = wdata_i;
        end

        busy_d = (state_d == MD_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, back-to-back
// starts, HI/LO writes, mid-run reset and random operations vs a reference model.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] src1_i = '0, src2_i = '0;
    logic        hi_we_i = 1'b0, lo_we_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .src1_i(src1_i), .src2_i(src2_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i),
        .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural definitions.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called #1 after a rising edge; start is accepted at the next edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
        @(posedge clk_i); #1;
        start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
        op_i = 2'($urandom); src1_i = $urandom; src2_i = $urandom;
        chk("busy_after_start", 64'(busy_o), 64'd1);
    endtask

    task automatic finish(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit junk);
        logic [63:0] res;
        int k;
        k = 0;
        res = ref_model(op, a, b);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_i); #1;
            if (junk && i == 10) begin
                start_i = 1'b1; op_i = 2'b01; src1_i = 32'd3; src2_i = 32'd3;
                hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = $urandom;
            end else begin
                start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
            end
            if (done_o) begin k = i; break; end
            chk({tag, "_hold"}, {hi_o, lo_o}, {exp_hi, exp_lo});
        end
        start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
        chk({tag, "_latency"}, 64'(k), 64'd32);
        chk({tag, "_busy_low"}, 64'(busy_o), 64'd0);
        chk({tag, "_hi"}, 64'(hi_o), 64'(res[63:32]));
        chk({tag, "_lo"}, 64'(lo_o), 64'(res[31:0]));
        exp_hi = res[63:32];
        exp_lo = res[31:0];
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        launch(op, a, b);
        finish(tag, op, a, b, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int done_seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        rst_i = 1'b0;

        // mthi in IDLE
        hi_we_i = 1'b1; wdata_i = 32'h1234;
        @(posedge clk_i); #1;
        hi_we_i = 1'b0;
        exp_hi = 32'h1234;
        chk("mthi_idle", 64'(hi_o), 64'h1234);
        chk("mthi_no_done", 64'(done_o), 64'd0);

        // mtlo together with an accepted start is dropped
        lo_we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mtlo_dropped_lo", 64'(lo_o), 64'(exp_lo));
        chk("mtlo_dropped_hi", 64'(hi_o), 64'(exp_hi));
        finish("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max_hi_const", 64'(hi_o), 64'hFFFF_FFFE);
        chk("multu_max_lo_const", 64'(lo_o), 64'h1);

        do_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
        chk("mult_m3x5_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu_by0", 2'b11, 32'd100, 32'd0);
        chk("divu_by0_const", {hi_o, lo_o}, {32'd100, 32'hFFFF_FFFF});
        do_op("div_by0_neg", 2'b10, 32'hFFFF_FF00, 32'd0);
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", {hi_o, lo_o}, {32'h0, 32'h8000_0000});

        // back-to-back: second start issued during the DONE cycle, junk during RUN
        launch(2'b11, 32'd9, 32'd4);
        finish("b2b_divu", 2'b11, 32'd9, 32'd4, 1'b1);
        chk("b2b_divu_done", 64'(done_o), 64'd1);
        launch(2'b01, 32'd6, 32'd7);
        finish("b2b_multu", 2'b01, 32'd6, 32'd7, 1'b1);
        chk("b2b_multu_const", {hi_o, lo_o}, {32'd0, 32'd42});
        @(posedge clk_i); #1;
        chk("done_one_cycle", 64'(done_o), 64'd0);
        chk("idle_after_done", 64'(busy_o), 64'd0);

        // random operations
        for (int t = 0; t < 40; t++) begin
            rop = 2'($urandom);
            ra = pick_operand();
            rb = pick_operand();
            do_op("rand", rop, ra, rb);
        end

        // reset in the middle of a run
        launch(2'b00, 32'd123, 32'd456);
        repeat (9) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_hi = '0; exp_lo = '0;
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (done_o) done_seen++;
        end
        chk("midrst_no_done", 64'(done_seen), 64'd0);
        chk("midrst_hilo_held", {hi_o, lo_o}, 64'd0);

        do_op("after_rst", 2'b10, 32'hFFFF_FF9C, 32'd7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
